// File: rtl/maxpool_window_ctrl_if.sv
// rtl/maxpool_window_ctrl_if.sv - frame/window handshake bundle for the 2x2 max-pool sequencer
// master drives Start/Valid_In (stream side); slave is the controller.
interface maxpool_window_ctrl_if #(
    parameter int IMG_WIDHT  = 220,
    parameter int IMG_HEIGHT = 220
);
    localparam int OUT_W = IMG_WIDHT / 2;
    localparam int OUT_H = IMG_HEIGHT / 2;
    localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic           Start;
    logic           Valid_In;
    logic           Window_Valid;
    logic [OCW-1:0] Out_Col;
    logic [ORW-1:0] Out_Row;
    logic           Busy;
    logic           Frame_Done;
    logic           Err_Sticky;

    modport master (
        output Start, Valid_In,
        input  Window_Valid, Out_Col, Out_Row, Busy, Frame_Done, Err_Sticky
    );

    modport slave (
        input  Start, Valid_In,
        output Window_Valid, Out_Col, Out_Row, Busy, Frame_Done, Err_Sticky
    );
endinterface

// File: rtl/maxpool_window_ctrl.sv
// rtl/maxpool_window_ctrl.sv - raster row/col tracker emitting 2x2 stride-2 window strobes
// Optional MAXPOOL_AUTO_RESTART_EN: DONE re-enters RUN so back-to-back frames need no Start.
module maxpool_window_ctrl #(
    parameter int IMG_WIDHT  = 220,
    parameter int IMG_HEIGHT = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    maxpool_window_ctrl_if.slave  bus
);
    localparam int OUT_W = IMG_WIDHT / 2;
    localparam int OUT_H = IMG_HEIGHT / 2;
    localparam int CW    = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
    localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDHT - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
    localparam logic [31:0]   COL_LIM = 32'(2 * OUT_W);
    localparam logic [31:0]   ROW_LIM = 32'(2 * OUT_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            win_q, win_d;
    logic [OCW-1:0]  out_col_q, out_col_d;
    logic [ORW-1:0]  out_row_q, out_row_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            col_last;
    logic            row_last;
    logic            win_hit;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        win_d     = 1'b0;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        accept    = 1'b0;
        col_last  = (col_q == COL_MAX);
        row_last  = (row_q == ROW_MAX);
        // Floor semantics: a trailing odd row/column never closes a window.
        win_hit   = row_q[0] & col_q[0]
                  & (32'(row_q) < ROW_LIM) & (32'(col_q) < COL_LIM);

        case (state_q)
            S_IDLE: begin
                if (bus.Valid_In) begin
                    err_d = 1'b1;
                end
                if (bus.Start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                accept = bus.Valid_In;
            end
            S_DONE: begin
`ifdef MAXPOOL_AUTO_RESTART_EN
                // Counters were cleared on the last pixel, so a beat here is (0,0).
                state_d = S_RUN;
                busy_d  = 1'b1;
                col_d   = '0;
                row_d   = '0;
                accept  = bus.Valid_In;
`else
                state_d = S_IDLE;
                if (bus.Valid_In) begin
                    err_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) begin
            if (win_hit) begin
                win_d     = 1'b1;
                out_col_d = OCW'(col_q >> 1);
                out_row_d = ORW'(row_q >> 1);
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (col_last && row_last) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= 1'b0;
            out_col_q <= '0;
            out_row_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.Window_Valid = win_q;
    assign bus.Out_Col      = out_col_q;
    assign bus.Out_Row      = out_row_q;
    assign bus.Busy         = busy_q;
    assign bus.Frame_Done   = done_q;
    assign bus.Err_Sticky   = err_q;
endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// tb/tb_maxpool_window_ctrl.sv - scoreboard bench for maxpool_window_ctrl (4x4 and 5x3 instances)
module tb_maxpool_window_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  checks = 0;
    int  errors = 0;
    logic start_r = 1'b0;
    logic vin_r   = 1'b0;
    logic sel     = 1'b0;

    maxpool_window_ctrl_if #(.IMG_WIDHT(4), .IMG_HEIGHT(4)) if_a();
    maxpool_window_ctrl_if #(.IMG_WIDHT(5), .IMG_HEIGHT(3)) if_b();

    assign if_a.Start    = start_r & ~sel;
    assign if_a.Valid_In = vin_r & ~sel;
    assign if_b.Start    = start_r & sel;
    assign if_b.Valid_In = vin_r & sel;

    maxpool_window_ctrl #(.IMG_WIDHT(4), .IMG_HEIGHT(4)) u_a (.clk(clk), .rst(rst_n), .bus(if_a));
    maxpool_window_ctrl #(.IMG_WIDHT(5), .IMG_HEIGHT(3)) u_b (.clk(clk), .rst(rst_n), .bus(if_b));

    typedef struct { int cyc; int row; int col; } win_t;
    win_t wq_a[$];
    win_t wq_b[$];
    int   dq_a[$];
    int   dq_b[$];
    win_t ea;
    win_t eb;

    // Hand-computed windows: 4x4 (and a second back-to-back 4x4 frame), 5x3.
    int a_beat[8] = '{6, 8, 14, 16, 22, 24, 30, 32};
    int a_row[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};
    int a_col[8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
    int b_beat[8] = '{7, 9, 0, 0, 0, 0, 0, 0};
    int b_row[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    int b_col[8]  = '{0, 1, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (if_a.Window_Valid === 1'b1) begin
            if (wq_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_window: row %0d col %0d at cycle %0d", if_a.Out_Row, if_a.Out_Col, cyc);
            end else begin
                ea = wq_a.pop_front();
                chk("a_win_cycle", cyc, ea.cyc);
                chk("a_win_row", int'(if_a.Out_Row), ea.row);
                chk("a_win_col", int'(if_a.Out_Col), ea.col);
            end
        end
        if (if_a.Frame_Done === 1'b1) begin
            if (dq_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_done: at cycle %0d", cyc);
            end else begin
                chk("a_done_cycle", cyc, dq_a.pop_front());
            end
            chk("a_busy_in_done", int'(if_a.Busy), 0);
        end
        if (if_b.Window_Valid === 1'b1) begin
            if (wq_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_window: row %0d col %0d at cycle %0d", if_b.Out_Row, if_b.Out_Col, cyc);
            end else begin
                eb = wq_b.pop_front();
                chk("b_win_cycle", cyc, eb.cyc);
                chk("b_win_row", int'(if_b.Out_Row), eb.row);
                chk("b_win_col", int'(if_b.Out_Col), eb.col);
            end
        end
        if (if_b.Frame_Done === 1'b1) begin
            if (dq_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_done: at cycle %0d", cyc);
            end else begin
                chk("b_done_cycle", cyc, dq_b.pop_front());
            end
            chk("b_busy_in_done", int'(if_b.Busy), 0);
        end
    end

    task automatic run_frame(input logic s, input int total, input int fpx, input int nw,
                             input int wb[8], input int wr[8], input int wc[8],
                             input int duty, input int start_mid, input int abort_at,
                             input logic start_with_vin);
        int   beat  = 0;
        int   k     = 0;
        int   guard = 0;
        logic v;
        sel = s;
        @(posedge clk); #1;
        start_r = 1'b1;
        vin_r   = start_with_vin;
        @(posedge clk); #1;
        start_r = 1'b0;
        vin_r   = 1'b0;
        chk(s ? "b_busy_after_start" : "a_busy_after_start", s ? int'(if_b.Busy) : int'(if_a.Busy), 1);
        while (beat < total && guard < 2000) begin
            guard++;
            v = (duty >= 100) || ($urandom_range(0, 99) < duty);
            vin_r   = v;
            start_r = v && (beat + 1 == start_mid);
            if (v) begin
                beat++;
                if (k < nw && beat == wb[k]) begin
                    if (s) wq_b.push_back('{cyc + 1, wr[k], wc[k]});
                    else   wq_a.push_back('{cyc + 1, wr[k], wc[k]});
                    k++;
                end
                if (beat % fpx == 0) begin
                    if (s) dq_b.push_back(cyc + 1);
                    else   dq_a.push_back(cyc + 1);
                end
            end
            @(posedge clk); #1;
            vin_r   = 1'b0;
            start_r = 1'b0;
            if (beat == abort_at) break;
        end
        if (guard >= 2000) begin
            checks++; errors++;
            $display("FAIL frame_timeout: only %0d of %0d beats issued", beat, total);
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_windows_outstanding"}, wq_a.size() + wq_b.size(), 0);
        chk({tag, "_done_outstanding"}, dq_a.size() + dq_b.size(), 0);
        chk({tag, "_busy_after"}, int'(if_a.Busy) + int'(if_b.Busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_outputs"}, int'({if_a.Window_Valid, if_a.Busy, if_a.Frame_Done,
                                       if_a.Err_Sticky, if_a.Out_Col, if_a.Out_Row}), 0);
        chk({tag, "_b_outputs"}, int'({if_b.Window_Valid, if_b.Busy, if_b.Frame_Done,
                                       if_b.Err_Sticky, if_b.Out_Col, if_b.Out_Row}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

`ifdef MAXPOOL_AUTO_RESTART_EN
        run_frame(1'b0, 32, 16, 8, a_beat, a_row, a_col, 100, 0, -1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("auto_windows_outstanding", wq_a.size(), 0);
        chk("auto_done_outstanding", dq_a.size(), 0);
        chk("auto_err_sticky", int'(if_a.Err_Sticky), 0);
`else
        // 4x4 continuous, then 50% duty stalls.
        run_frame(1'b0, 16, 16, 4, a_beat, a_row, a_col, 100, 0, -1, 1'b0);
        drain("basic");
        run_frame(1'b0, 16, 16, 4, a_beat, a_row, a_col, 50, 0, -1, 1'b0);
        drain("stalled");

        // 5x3: only two windows survive the floor.
        run_frame(1'b1, 15, 15, 2, b_beat, b_row, b_col, 100, 0, -1, 1'b0);
        drain("odd");
        chk("odd_err_clear", int'(if_b.Err_Sticky), 0);

        // Start with Valid_In in IDLE: frame starts, pixel dropped, error flagged.
        run_frame(1'b1, 15, 15, 2, b_beat, b_row, b_col, 100, 0, -1, 1'b1);
        drain("start_with_valid");
        chk("start_with_valid_err", int'(if_b.Err_Sticky), 1);

        // Stray Valid_In in IDLE, then a frame with Start pulsed mid-RUN.
        sel = 1'b0;
        @(posedge clk); #1;
        vin_r = 1'b1;
        @(posedge clk); #1;
        vin_r = 1'b0;
        chk("idle_valid_err", int'(if_a.Err_Sticky), 1);
        chk("idle_valid_busy", int'(if_a.Busy), 0);
        run_frame(1'b0, 16, 16, 4, a_beat, a_row, a_col, 100, 5, -1, 1'b0);
        drain("start_mid_run");
        chk("err_still_sticky", int'(if_a.Err_Sticky), 1);

        // Reset after beat 9: nothing further, no Frame_Done.
        run_frame(1'b0, 16, 16, 4, a_beat, a_row, a_col, 100, 0, 9, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain("after_reset");
        run_frame(1'b0, 16, 16, 4, a_beat, a_row, a_col, 100, 0, -1, 1'b0);
        drain("post_reset_frame");
        chk("post_reset_err", int'(if_a.Err_Sticky), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
